axi4_ram_slave: RTL
===================

Name: axi4_ram_slave

Overview:
- AXI4 memory-mapped responder; the slave end of the mem_wr/mem_rd master ports driven by the frame write/read controllers.
- Backs a single-clock word-addressed RAM.
- Used as the memory model in frame buffer benches and as an on-chip line/frame store for small resolutions.
- Write (AW/W/B) and read (AR/R) paths are independent and run concurrently.

Parameters:
- ADDR_WIDTH, 32: AXI address width.
- DATA_WIDTH, 64: AXI data width; power of two, at least 8.
- ID_WIDTH, 1: AXI ID width; IDs are echoed on BID and RID.
- WORDS_AMOUNT, 1024: RAM depth in DATA_WIDTH words.
- BASE_ADDR, 0: byte address of word 0; must be aligned to DATA_WIDTH/8.

Ports:
- clk_i  input  1  single clock for all channels.
- rst_i  input  1  asynchronous, active-high reset.
- mem  axi4_if.slave  interface  AXI4 slave port; ADDR_WIDTH/DATA_WIDTH/ID_WIDTH per parameters.

Behaviour:
- Reset values:
  - awready, wready, bvalid, arready, rvalid, rlast: 0.
  - bresp, rresp, rdata, bid, rid: 0.
  - RAM contents are not reset.
- After reset release, awready and arready rise on the first clock edge.
- Address mapping:
  - word = (addr - BASE_ADDR) >> log2(DATA_WIDTH/8).
  - In range iff addr >= BASE_ADDR and word < WORDS_AMOUNT.
  - All burst types are treated as INCR; the word index increments by 1 per beat.
  - awsize/arsize are ignored; full width is assumed.
- Write FSM, states WR_IDLE -> WR_DATA -> WR_RESP:
  - WR_IDLE: awready=1. On AW handshake, latch word, awlen, awid and clear the error flag; next state WR_DATA.
  - WR_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb, then word+1.
  - Out-of-range beat: write is dropped and the error flag is set.
  - The burst ends on beat awlen+1. If wlast disagrees with the beat count (early or missing), the error flag is set and the burst still ends on the count.
  - WR_RESP: bvalid=1, bid=latched id, bresp = 2'b10 (SLVERR) if the error flag is set, else 2'b00. Hold until bready; then WR_IDLE with awready=1 on the next cycle.
- Read FSM, states RD_IDLE -> RD_DATA:
  - RD_IDLE: arready=1. On AR handshake, the RAM is read at araddr's word; rvalid=1 on the next cycle.
  - RD_DATA: rdata is registered. On each R handshake (rvalid && rready), the next word is read on the same edge, giving full throughput with no bubbles. rvalid holds while !rready, with rdata stable.
  - rlast=1 on beat arlen+1. After the last handshake, rvalid drops and the FSM returns to RD_IDLE (arready=1 that cycle).
  - Out-of-range beats return rdata=0 and rresp=2'b10 per beat; in-range beats return 2'b00. rid = latched arid.
- Concurrency and boundary cases:
  - Same-cycle read and write to the same word: read returns the old data (read-before-write).
  - Reset mid-burst: all valid/ready outputs drop immediately; the in-flight burst is discarded with no response issued. Previously written RAM data is preserved.
- Latency: AR handshake to first rvalid is 1 cycle; last W handshake to bvalid is 1 cycle.

Optional Feature:
- Macro AXI4_RAM_SLAVE_STATS_EN.
- When defined, adds three 32-bit outputs:
  - wr_bursts_o: +1 per B handshake.
  - rd_bursts_o: +1 per R handshake with rlast.
  - err_cnt_o: +1 per B handshake with SLVERR and per R beat handshake with SLVERR.
- Counters wrap at 2^32 and reset to 0.
- When undefined, these ports and counters do not exist and behaviour is otherwise identical.

Decomposition:
- Package axi4_ram_slave_pkg holds:
  - enums wr_state_t {WR_IDLE, WR_DATA, WR_RESP} and rd_state_t {RD_IDLE, RD_DATA};
  - constants RESP_OKAY=2'b00 and RESP_SLVERR=2'b10.
- Sub-module axi4_ram_array: simple dual-port RAM with byte-enable write port, registered read port with read enable, read-before-write.

Test Plan:
- Write burst at AW 0x100 (len 7, data 0..7, wstrb 0xFF), then AR 0x100 (len 7) -> bresp 0; rdata 0..7 with rlast on beat 8; rresp 0 on every beat.
- Word 0 holds all-ones; write 0x1122334455667788 with wstrb 0x0F -> readback is 0xFFFFFFFF55667788.
- AR len 255 with rready toggling every cycle and a concurrent write burst elsewhere -> exactly 256 beats, in order, no duplicates; write bresp 0.
- AW 0x2000 (word 1024, out of range) -> bresp 2'b10, RAM unchanged. AR 0x1FF8 len 1 -> beat0 rresp 0 with stored data; beat1 rresp 2'b10 with rdata 0.
- AW len 7 with wlast asserted on beat 4 -> 8 beats accepted, bresp 2'b10, bid = awid.
- Assert rst_i during beat 3 of a read burst -> rvalid/arready drop immediately; after release, arready=1 next cycle and earlier written data reads back intact.

Source files
------------

// File: rtl/axi4_ram_slave_pkg.sv
// Shared types and response codes for the AXI4 RAM responder.
package axi4_ram_slave_pkg;

   typedef enum logic [1:0] {WR_IDLE, WR_DATA, WR_RESP} wr_state_t;
   typedef enum logic {RD_IDLE, RD_DATA} rd_state_t;

   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/axi4_if.sv
// AXI4 memory-mapped bus bundle with master and slave views.
interface axi4_if #(
   parameter int unsigned ADDR_WIDTH = 32,
   parameter int unsigned DATA_WIDTH = 64,
   parameter int unsigned ID_WIDTH   = 1
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;
   logic [ID_WIDTH-1:0]     rid;
   logic [DATA_WIDTH-1:0]   rdata;
   logic [1:0]              rresp;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid, output awready,
      input  wdata, wstrb, wlast, wvalid, output wready,
      output bid, bresp, bvalid, input bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid, output arready,
      output rid, rdata, rresp, rlast, rvalid, input rready
   );

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid, input awready,
      output wdata, wstrb, wlast, wvalid, input wready,
      input  bid, bresp, bvalid, output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid, input arready,
      input  rid, rdata, rresp, rlast, rvalid, output rready
   );

endinterface

// File: rtl/axi4_ram_array.sv
// Simple dual-port RAM: byte-enabled write port, registered read port with
// enable; a same-cycle read of the written word returns the old contents.
module axi4_ram_array #(
   parameter int unsigned DATA_WIDTH   = 64,
   parameter int unsigned WORDS_AMOUNT = 1024,
   parameter int unsigned ADDR_BITS    = 10
) (
   input  logic                    clk,
   input  logic                    we,
   input  logic [ADDR_BITS-1:0]    waddr,
   input  logic [DATA_WIDTH-1:0]   wdata,
   input  logic [DATA_WIDTH/8-1:0] wstrb,
   input  logic                    re,
   input  logic [ADDR_BITS-1:0]    raddr,
   output logic [DATA_WIDTH-1:0]   rdata
);

   logic [DATA_WIDTH-1:0] ram [WORDS_AMOUNT];

   always_ff @(posedge clk) begin
      if (we) begin
         for (int b = 0; b < DATA_WIDTH / 8; b++) begin
            if (wstrb[b]) ram[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
         end
      end
      if (re) rdata <= ram[raddr];
   end

endmodule

// File: rtl/axi4_ram_slave.sv
// AXI4 slave backed by a word-addressed RAM; independent write and read FSMs.
// Define AXI4_RAM_SLAVE_STATS_EN to add burst/error statistics counters.
module axi4_ram_slave
   import axi4_ram_slave_pkg::*;
#(
   parameter int unsigned           ADDR_WIDTH   = 32,
   parameter int unsigned           DATA_WIDTH   = 64,
   parameter int unsigned           ID_WIDTH     = 1,
   parameter int unsigned           WORDS_AMOUNT = 1024,
   parameter logic [ADDR_WIDTH-1:0] BASE_ADDR    = '0
) (
   input  logic        clk_i,
   input  logic        rst_i,
   axi4_if.slave       mem
`ifdef AXI4_RAM_SLAVE_STATS_EN
   ,
   output logic [31:0] wr_bursts_o,
   output logic [31:0] rd_bursts_o,
   output logic [31:0] err_cnt_o
`endif
);

   localparam int unsigned OFFS = $clog2(DATA_WIDTH / 8);
   localparam int unsigned RAM_AW = (WORDS_AMOUNT > 1) ? $clog2(WORDS_AMOUNT) : 1;
   localparam logic [ADDR_WIDTH-1:0] WORDS_LIM = ADDR_WIDTH'(WORDS_AMOUNT);
   localparam logic [ADDR_WIDTH-1:0] ONE = ADDR_WIDTH'(1);

   wr_state_t wr_state_q, wr_state_d;
   rd_state_t rd_state_q, rd_state_d;
   logic      init_q;

   logic [ADDR_WIDTH-1:0] aw_word, ar_word, wr_word_q, rd_word_q;
   logic                  aw_base_ok, ar_base_ok, wr_base_ok_q, rd_base_ok_q;
   logic [7:0]            wr_len_q, wr_beat_q, rd_len_q, rd_beat_q;
   logic [ID_WIDTH-1:0]   wr_id_q, rd_id_q;
   logic                  wr_err_q, rd_last_q, rd_oor_q;
   logic                  aw_hs, w_hs, b_hs, ar_hs, r_hs, w_last_beat, wr_in_range;
   logic                  ram_we, ram_re;
   logic [RAM_AW-1:0]     ram_raddr;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  unused_sig;

   assign unused_sig = ^{mem.awsize, mem.awburst, mem.arsize, mem.arburst};

   assign aw_base_ok = mem.awaddr >= BASE_ADDR;
   assign ar_base_ok = mem.araddr >= BASE_ADDR;
   assign aw_word    = (mem.awaddr - BASE_ADDR) >> OFFS;
   assign ar_word    = (mem.araddr - BASE_ADDR) >> OFFS;

   assign aw_hs = mem.awvalid && mem.awready;
   assign w_hs  = mem.wvalid && mem.wready;
   assign b_hs  = mem.bvalid && mem.bready;
   assign ar_hs = mem.arvalid && mem.arready;
   assign r_hs  = mem.rvalid && mem.rready;

   assign w_last_beat = wr_beat_q == wr_len_q;
   assign wr_in_range = wr_base_ok_q && (wr_word_q < WORDS_LIM);
   assign ram_we      = w_hs && wr_in_range;
   // Prefetch the next beat on the handshake edge so R runs without bubbles.
   assign ram_re      = ar_hs || (r_hs && !rd_last_q);
   assign ram_raddr   = ar_hs ? ar_word[RAM_AW-1:0] : rd_word_q[RAM_AW-1:0];

   axi4_ram_array #(
      .DATA_WIDTH   (DATA_WIDTH),
      .WORDS_AMOUNT (WORDS_AMOUNT),
      .ADDR_BITS    (RAM_AW)
   ) u_ram (
      .clk   (clk_i),
      .we    (ram_we),
      .waddr (wr_word_q[RAM_AW-1:0]),
      .wdata (mem.wdata),
      .wstrb (mem.wstrb),
      .re    (ram_re),
      .raddr (ram_raddr),
      .rdata (ram_rdata)
   );

   // Holds both ready outputs low until the first edge after reset.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         init_q     <= 1'b0;
         wr_state_q <= WR_IDLE;
         rd_state_q <= RD_IDLE;
      end else begin
         init_q     <= 1'b1;
         wr_state_q <= wr_state_d;
         rd_state_q <= rd_state_d;
      end
   end

   always_comb begin
      wr_state_d = wr_state_q;
      unique case (wr_state_q)
         WR_IDLE: if (aw_hs) wr_state_d = WR_DATA;
         WR_DATA: if (w_hs && w_last_beat) wr_state_d = WR_RESP;
         WR_RESP: if (b_hs) wr_state_d = WR_IDLE;
         default: wr_state_d = WR_IDLE;
      endcase
   end

   always_comb begin
      rd_state_d = rd_state_q;
      unique case (rd_state_q)
         RD_IDLE: if (ar_hs) rd_state_d = RD_DATA;
         RD_DATA: if (r_hs && rd_last_q) rd_state_d = RD_IDLE;
         default: rd_state_d = RD_IDLE;
      endcase
   end

   always_comb begin
      mem.awready = init_q && (wr_state_q == WR_IDLE);
      mem.wready  = wr_state_q == WR_DATA;
      mem.bvalid  = wr_state_q == WR_RESP;
      mem.bresp   = (mem.bvalid && wr_err_q) ? RESP_SLVERR : RESP_OKAY;
      mem.bid     = wr_id_q;
      mem.arready = init_q && (rd_state_q == RD_IDLE);
      mem.rvalid  = rd_state_q == RD_DATA;
      mem.rlast   = mem.rvalid && rd_last_q;
      mem.rresp   = (mem.rvalid && rd_oor_q) ? RESP_SLVERR : RESP_OKAY;
      mem.rdata   = (mem.rvalid && !rd_oor_q) ? ram_rdata : '0;
      mem.rid     = rd_id_q;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_word_q    <= '0;
         wr_base_ok_q <= 1'b0;
         wr_len_q     <= '0;
         wr_beat_q    <= '0;
         wr_id_q      <= '0;
         wr_err_q     <= 1'b0;
      end else if (aw_hs) begin
         wr_word_q    <= aw_word;
         wr_base_ok_q <= aw_base_ok;
         wr_len_q     <= mem.awlen;
         wr_beat_q    <= '0;
         wr_id_q      <= mem.awid;
         wr_err_q     <= 1'b0;
      end else if (w_hs) begin
         wr_word_q <= wr_word_q + ONE;
         wr_beat_q <= wr_beat_q + 8'd1;
         if (!wr_in_range || (mem.wlast != w_last_beat)) wr_err_q <= 1'b1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         rd_word_q    <= '0;
         rd_base_ok_q <= 1'b0;
         rd_len_q     <= '0;
         rd_beat_q    <= '0;
         rd_id_q      <= '0;
         rd_last_q    <= 1'b0;
         rd_oor_q     <= 1'b0;
      end else if (ar_hs) begin
         rd_word_q    <= ar_word + ONE;
         rd_base_ok_q <= ar_base_ok;
         rd_len_q     <= mem.arlen;
         rd_beat_q    <= '0;
         rd_id_q      <= mem.arid;
         rd_last_q    <= mem.arlen == 8'd0;
         rd_oor_q     <= !(ar_base_ok && (ar_word < WORDS_LIM));
      end else if (r_hs && !rd_last_q) begin
         rd_word_q <= rd_word_q + ONE;
         rd_beat_q <= rd_beat_q + 8'd1;
         rd_last_q <= (rd_beat_q + 8'd1) == rd_len_q;
         rd_oor_q  <= !(rd_base_ok_q && (rd_word_q < WORDS_LIM));
      end
   end

`ifdef AXI4_RAM_SLAVE_STATS_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         wr_bursts_o <= '0;
         rd_bursts_o <= '0;
         err_cnt_o   <= '0;
      end else begin
         if (b_hs) wr_bursts_o <= wr_bursts_o + 32'd1;
         if (r_hs && mem.rlast) rd_bursts_o <= rd_bursts_o + 32'd1;
         err_cnt_o <= err_cnt_o + 32'(b_hs && (mem.bresp == RESP_SLVERR))
                                + 32'(r_hs && (mem.rresp == RESP_SLVERR));
      end
   end
`endif

endmodule
